// File: rtl/if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buffer
// Description : Two-entry IF/ID skid buffer (head + skid) with registered
//               in_ready, bubble insertion, flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_buffer #(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 16,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_buff_in,
    input  logic [INST_W-1:0] inst_buff_in,
    input  logic              nop_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_buff_out,
    output logic [INST_W-1:0] inst_buff_out,
    output logic [1:0]        count_out
);

    logic              r_head_valid;
    logic [PC_W-1:0]   r_head_pc;
    logic [INST_W-1:0] r_head_inst;
    logic              r_skid_valid;
    logic [PC_W-1:0]   r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_head_free;
    logic              w_skid_valid_nxt;
    logic [INST_W-1:0] w_in_inst;

    assign w_accept    = in_valid & r_in_ready;
    assign w_head_free = ~r_head_valid | out_ready;
    assign w_in_inst   = nop_in ? NOP_INST : inst_buff_in;

    // Skid stays occupied only while the head cannot drain into decode.
    assign w_skid_valid_nxt = w_head_free ? (r_skid_valid & w_accept)
                                          : (r_skid_valid | w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_pc    <= '0;
            r_head_inst  <= NOP_INST;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= NOP_INST;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            // Data registers keep their contents so pc_buff_out holds.
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_head_free) begin
                if (r_skid_valid) begin
                    r_head_valid <= 1'b1;
                    r_head_pc    <= r_skid_pc;
                    r_head_inst  <= r_skid_inst;
                    if (w_accept) begin
                        r_skid_pc   <= pc_buff_in;
                        r_skid_inst <= w_in_inst;
                    end
                end else begin
                    r_head_valid <= w_accept;
                    if (w_accept) begin
                        r_head_pc   <= pc_buff_in;
                        r_head_inst <= w_in_inst;
                    end
                end
            end else if (w_accept) begin
                r_skid_pc   <= pc_buff_in;
                r_skid_inst <= w_in_inst;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_head_valid;
    assign pc_buff_out   = r_head_pc;
    assign inst_buff_out = r_head_valid ? r_head_inst : NOP_INST;
    assign count_out     = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid_buffer
// Description : Directed self-checking bench; drives a 16-bit and a 32-bit
//               instance with identical control and width-matched data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_buffer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, nop_in, out_ready;
    logic [31:0] pc_in, inst_in;

    logic        ir16, ov16, ir32, ov32;
    logic [1:0]  cnt16, cnt32;
    logic [15:0] pco16, insto16;
    logic [31:0] pco32, insto32;

    logic [35:0] obs16, e16;
    logic [67:0] obs32, e32;
    int          n_checks = 0;
    int          n_pass   = 0;

    assign obs16 = {ov16, ir16, cnt16, pco16, insto16};
    assign obs32 = {ov32, ir32, cnt32, pco32, insto32};

    always #5 clk = ~clk;

    if_id_skid_buffer dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir16),
        .pc_buff_in(pc_in[15:0]), .inst_buff_in(inst_in[15:0]), .nop_in(nop_in),
        .out_valid(ov16), .out_ready(out_ready),
        .pc_buff_out(pco16), .inst_buff_out(insto16), .count_out(cnt16)
    );

    if_id_skid_buffer #(.PC_W(32), .INST_W(32), .NOP_INST(32'h0000_0013)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir32),
        .pc_buff_in(pc_in), .inst_buff_in(inst_in), .nop_in(nop_in),
        .out_valid(ov32), .out_ready(out_ready),
        .pc_buff_out(pco32), .inst_buff_out(insto32), .count_out(cnt32)
    );

    // Expected observation vectors; an invalid or bubble head shows that width's NOP.
    function automatic logic [35:0] exp16(input logic v, input logic r, input logic [1:0] c,
                                          input logic nop, input logic [31:0] pc,
                                          input logic [31:0] inst);
        return {v, r, c, pc[15:0], (v && !nop) ? inst[15:0] : 16'h0000};
    endfunction

    function automatic logic [67:0] exp32(input logic v, input logic r, input logic [1:0] c,
                                          input logic nop, input logic [31:0] pc,
                                          input logic [31:0] inst);
        return {v, r, c, pc, (v && !nop) ? inst : 32'h0000_0013};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        pc_in    = pc;
        inst_in  = inst;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; nop_in = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        e16 = exp16(0, 1, 2'd0, 0, 32'h0, 32'h0); e32 = exp32(0, 1, 2'd0, 0, 32'h0, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL reset_state: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        step();
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL reset_idle: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
    endtask

    task automatic test_pass_through();
        out_ready = 1'b1;
        drive(1'b1, 32'hABCD_1234, 32'h8765_4321);
        step();
        drive(1'b0, 32'h0, 32'h0);
        e16 = exp16(1, 1, 2'd1, 0, 32'hABCD_1234, 32'h8765_4321);
        e32 = exp32(1, 1, 2'd1, 0, 32'hABCD_1234, 32'h8765_4321);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL pass_out: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        step();
        e16 = exp16(0, 1, 2'd0, 0, 32'hABCD_1234, 32'h0);
        e32 = exp32(0, 1, 2'd0, 0, 32'hABCD_1234, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL pass_drain: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h2222_1111, 32'hEEEE_FFFF);
        step();
        e16 = exp16(1, 1, 2'd1, 0, 32'h2222_1111, 32'hEEEE_FFFF);
        e32 = exp32(1, 1, 2'd1, 0, 32'h2222_1111, 32'hEEEE_FFFF);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bp_one: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        drive(1'b1, 32'h5555_AAAA, 32'h7531_1597);
        step();
        e16 = exp16(1, 0, 2'd2, 0, 32'h2222_1111, 32'hEEEE_FFFF);
        e32 = exp32(1, 0, 2'd2, 0, 32'h2222_1111, 32'hEEEE_FFFF);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bp_full: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        // Beat offered while full must be refused.
        drive(1'b1, 32'h6666_DDDD, 32'h6666_DDDD);
        step();
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bp_refuse: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        e16 = exp16(1, 1, 2'd1, 0, 32'h5555_AAAA, 32'h7531_1597);
        e32 = exp32(1, 1, 2'd1, 0, 32'h5555_AAAA, 32'h7531_1597);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bp_second: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        step();
        e16 = exp16(0, 1, 2'd0, 0, 32'h5555_AAAA, 32'h0);
        e32 = exp32(0, 1, 2'd0, 0, 32'h5555_AAAA, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bp_empty: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, inst;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc   = 32'hC0DE_0100 + k;
            inst = 32'hBEEF_0A00 + k;
            drive(1'b1, pc, inst);
            step();
            e16 = exp16(1, 1, 2'd1, 0, pc, inst); e32 = exp32(1, 1, 2'd1, 0, pc, inst);
            n_checks++;
            if (obs16 !== e16 || obs32 !== e32)
                $display("FAIL b2b_beat%0d: d16 %h want %h | d32 %h want %h", k, obs16, e16, obs32, e32);
            else n_pass++;
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        e16 = exp16(0, 1, 2'd0, 0, 32'hC0DE_0102, 32'h0);
        e32 = exp32(0, 1, 2'd0, 0, 32'hC0DE_0102, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL b2b_drain: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h1111_3000, 32'h1111_3001); step();
        drive(1'b1, 32'h1111_3100, 32'h1111_3101); step();
        e16 = exp16(1, 0, 2'd2, 0, 32'h1111_3000, 32'h1111_3001);
        e32 = exp32(1, 0, 2'd2, 0, 32'h1111_3000, 32'h1111_3001);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL flush_fill: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        flush = 1'b1;
        drive(1'b1, 32'h1111_3200, 32'h1111_3201);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        e16 = exp16(0, 1, 2'd0, 0, 32'h1111_3000, 32'h0);
        e32 = exp32(0, 1, 2'd0, 0, 32'h1111_3000, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL flush_full: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        out_ready = 1'b1;
        step(); step();
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL flush_no_leak: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        // Empty buffer: a beat handshaked in the flush cycle is still dropped.
        flush = 1'b1;
        drive(1'b1, 32'h1111_3300, 32'h1111_3301);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL flush_offered: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        nop_in = 1'b1;
        drive(1'b1, 32'h0000_0042, 32'hDEAD_BEEF);
        step();
        nop_in = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        e16 = exp16(1, 1, 2'd1, 1, 32'h0000_0042, 32'h0);
        e32 = exp32(1, 1, 2'd1, 1, 32'h0000_0042, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bubble_out: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        step();
        e16 = exp16(0, 1, 2'd0, 0, 32'h0000_0042, 32'h0);
        e32 = exp32(0, 1, 2'd0, 0, 32'h0000_0042, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL bubble_drain: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        drive(1'b1, 32'h4444_5000, 32'h4444_5001); step();
        drive(1'b1, 32'h4444_5100, 32'h4444_5101); step();
        e16 = exp16(1, 0, 2'd2, 0, 32'h4444_5000, 32'h4444_5001);
        e32 = exp32(1, 0, 2'd2, 0, 32'h4444_5000, 32'h4444_5001);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL rstmid_fill: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h4444_5200, 32'h4444_5201);
        step();
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        e16 = exp16(0, 1, 2'd0, 0, 32'h0, 32'h0); e32 = exp32(0, 1, 2'd0, 0, 32'h0, 32'h0);
        n_checks++;
        if (obs16 !== e16 || obs32 !== e32)
            $display("FAIL rstmid_state: d16 %h want %h | d32 %h want %h", obs16, e16, obs32, e32);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (obs16 !== e16 || obs32 !== e32)
                $display("FAIL rstmid_quiet%0d: d16 %h want %h | d32 %h want %h", k, obs16, e16, obs32, e32);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_bubble();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_skid_buffer.md
IF_ID_SKID_BUFFER -- requirements
Module: if_id_skid_buffer

Interface
REQ-001 The module SHALL have parameter PC_W, default 16, giving the program-counter width.
REQ-002 The module SHALL have parameter INST_W, default 16, giving the instruction width.
REQ-003 The module SHALL have parameter NOP_INST, default 16'h0000 (INST_W bits), giving the bubble instruction encoding.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 The module SHALL have port in_valid, input, 1 bit: the fetch stage presents a beat.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the buffer can accept a beat this cycle.
REQ-009 The module SHALL have port pc_buff_in, input, PC_W bits: PC of the incoming beat.
REQ-010 The module SHALL have port inst_buff_in, input, INST_W bits: instruction of the incoming beat.
REQ-011 The module SHALL have port nop_in, input, 1 bit: the accepted beat's instruction is replaced by NOP_INST.
REQ-012 The module SHALL have port out_valid, output, 1 bit: the decode stage is presented a beat.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the decode stage consumes the beat this cycle.
REQ-014 The module SHALL have port pc_buff_out, output, PC_W bits: PC of the head beat.
REQ-015 The module SHALL have port inst_buff_out, output, INST_W bits: instruction of the head beat.
REQ-016 The module SHALL have port count_out, output, 2 bits: occupancy, 0 to 2.

Function
REQ-017 The buffer SHALL hold two entries: a head register driving the outputs and a skid register, each with a valid bit.
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1; it SHALL be consumed when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be registered and equal to NOT skid_valid; it SHALL have no combinational path from out_ready.
REQ-020 An accepted beat SHALL appear on the outputs with out_valid=1 exactly 1 cycle after acceptance when the head is empty or being consumed.
REQ-021 An accepted beat that cannot enter the head (head full, not consumed) SHALL be written to the skid register.
REQ-022 On a consume with the skid register valid, the skid entry SHALL move to the head in the same edge, and the skid register SHALL take any simultaneously accepted beat.
REQ-023 Beats SHALL leave in acceptance order; no beat SHALL be duplicated or dropped except by flush or rst.
REQ-024 With nop_in=1 on acceptance, the stored instruction SHALL be NOP_INST and the stored PC SHALL be pc_buff_in.
REQ-025 While out_valid=0, inst_buff_out SHALL equal NOP_INST and pc_buff_out SHALL hold its last value.
REQ-026 flush=1 SHALL clear both valid bits at the next edge and set count_out=0 and in_ready=1; a beat offered in the same cycle SHALL be discarded.
REQ-027 Occupancy SHALL obey count_out = head_valid + skid_valid; count_out SHALL never exceed 2.
REQ-028 Simultaneous accept and consume at count 1 SHALL leave count at 1 with the new beat in the head.

Reset
REQ-029 When rst=1 at a rising edge, the module SHALL set: out_valid=0, in_ready=1, count_out=0, pc_buff_out=0, inst_buff_out=NOP_INST, skid register cleared.
REQ-030 rst SHALL take priority over flush, in_valid and out_ready, including mid-transfer.

Verification
REQ-031 Pass-through: with out_ready=1, accept pc=16'h1234/inst=16'h4321 -> next cycle out_valid=1, outputs 1234/4321, count_out=1.
REQ-032 Back-pressure: with out_ready=0, accept 1111/FFFF then AAAA/1597 -> count_out=2, in_ready=0; then raise out_ready -> outputs 1111/FFFF then AAAA/1597 in order, in_ready returns to 1.
REQ-033 Flush with full buffer plus a new beat offered: flush=1 -> next cycle out_valid=0, inst_buff_out=NOP_INST, count_out=0, and the offered beat never appears.
REQ-034 Bubble: accept pc=16'h0042 with nop_in=1 -> out_valid=1, pc_buff_out=0042, inst_buff_out=NOP_INST.
REQ-035 Reset mid-stream: assert rst with count_out=2 and in_valid=1 -> next cycle all outputs at reset values and no pre-reset beat emerges.
REQ-036 Parameter sweep: PC_W=32, INST_W=32, NOP_INST=32'h00000013 -> scenarios REQ-031 to REQ-035 pass with full-width values.
